bsg_cgol_seq_ctrl: RTL and testbench

Next-generation sequencing controller for the CGOL cell array. It generalises the fixed run-N-frames controller with:
- selectable run modes: run-N, single-step, free-run
- a multi-cycle frame pacing parameter
- stop/abort at frame boundaries
- an en_i freeze
- a reported generation count

It sits between the host valid/ready command channel and the cell array's update/enable controls.

---
 rtl/bsg_cgol_pkg.sv | 31 +++
 rtl/bsg_cgol_frame_pacer.sv | 43 ++++
 rtl/bsg_cgol_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_bsg_cgol_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cgol_pkg.sv
// Shared types for the CGOL sequencing controller: run modes, controller states
// and a width helper.
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        RUN_N = 2'd0,
        STEP  = 2'd1,
        FREE  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        OUTPUT
    } state_e;

    function automatic int safe_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    // Reserved encoding 3 behaves as RUN_N.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return STEP;
            2'd2:    return FREE;
            default: return RUN_N;
        endcase
    endfunction

endpackage

// File: rtl/bsg_cgol_frame_pacer.sv
// Frame phase counter: one en_o pulse at the start of each frame and a
// frame_done strobe on its last cycle; en_i=0 freezes the phase.
module bsg_cgol_frame_pacer
    import bsg_cgol_pkg::*;
#(
    parameter int cycles_per_frame_p = 1,
    localparam int phase_width_lp = safe_clog2(cycles_per_frame_p)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic run_i,
    input  logic en_i,
    output logic en_o,
    output logic frame_done_o
);

    localparam logic [phase_width_lp-1:0] last_phase_lp = phase_width_lp'(cycles_per_frame_p - 1);

    logic [phase_width_lp-1:0] phase_q, phase_d;
    logic active;

    assign active       = run_i & en_i;
    assign en_o         = active & (phase_q == '0);
    assign frame_done_o = active & (phase_q == last_phase_lp);

    always_comb begin
        phase_d = phase_q;
        if (!run_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = (phase_q == last_phase_lp) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/bsg_cgol_seq_ctrl.sv
// CGOL sequencing controller (run-N / single-step / free-run, paced frames).
// Optional: `define BSG_CGOL_CTRL_STABLE_EXIT_EN to end runs on stable_i.
module bsg_cgol_seq_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter int max_game_length_p  = 1023,
    parameter int cycles_per_frame_p = 1,
    localparam int game_len_width_lp = safe_clog2(max_game_length_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic [game_len_width_lp-1:0] frames_i,
    input  logic [1:0]                   mode_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic                         stop_i,
    input  logic                         stable_i,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [game_len_width_lp-1:0] frames_done_o,
    output logic                         stable_exit_o,
    output logic                         update_o,
    output logic                         en_o,
    output logic                         busy_o
);

    localparam logic [game_len_width_lp-1:0] max_frames_lp = game_len_width_lp'(max_game_length_p);
    localparam logic [game_len_width_lp-1:0] one_lp        = game_len_width_lp'(1);

    state_e                       state_q, state_d;
    mode_e                        mode_q, mode_d;
    logic [game_len_width_lp-1:0] remaining_q, remaining_d;
    logic [game_len_width_lp-1:0] frames_done_q, frames_done_d;

    logic pacer_en, frame_done;
    logic ready_raw, update_raw, v_raw, busy_raw;
    logic accept, run_exit, stable_hit, count_exit;

    bsg_cgol_frame_pacer #(
        .cycles_per_frame_p(cycles_per_frame_p)
    ) u_pacer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .run_i       (state_q == RUN),
        .en_i        (en_i),
        .en_o        (pacer_en),
        .frame_done_o(frame_done)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        remaining_d   = remaining_q;
        frames_done_d = frames_done_q;
        ready_raw     = 1'b0;
        update_raw    = 1'b0;
        v_raw         = 1'b0;
        busy_raw      = 1'b0;
        accept        = 1'b0;
        run_exit      = 1'b0;
        count_exit    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_raw = en_i;
                if (v_i && en_i) begin
                    accept        = 1'b1;
                    update_raw    = 1'b1;
                    mode_d        = decode_mode(mode_i);
                    remaining_d   = frames_i;
                    frames_done_d = '0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                busy_raw = 1'b1;
                state_d  = (mode_q == RUN_N && remaining_q == '0) ? OUTPUT : RUN;
            end
            RUN: begin
                busy_raw = 1'b1;
                if (frame_done) begin
                    frames_done_d = frames_done_q + 1'b1;
                    remaining_d   = remaining_q - 1'b1;
                    case (mode_q)
                        RUN_N:   count_exit = (remaining_q == one_lp);
                        STEP:    count_exit = 1'b1;
                        default: count_exit = (frames_done_d == max_frames_lp);
                    endcase
                    run_exit = count_exit | stop_i | stable_hit;
                    if (run_exit) begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                v_raw = 1'b1;
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            mode_q        <= RUN_N;
            remaining_q   <= '0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            remaining_q   <= remaining_d;
            frames_done_q <= frames_done_d;
        end
    end

`ifdef BSG_CGOL_CTRL_STABLE_EXIT_EN
    logic stable_exit_q, stable_exit_d;

    assign stable_hit = stable_i;

    always_comb begin
        stable_exit_d = stable_exit_q;
        if (accept) begin
            stable_exit_d = 1'b0;
        end else if (run_exit) begin
            stable_exit_d = stable_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stable_exit_q <= 1'b0;
        end else begin
            stable_exit_q <= stable_exit_d;
        end
    end

    assign stable_exit_o = reset_n_i & stable_exit_q;
`else
    logic unused_stable;

    assign unused_stable = stable_i | accept;
    assign stable_hit    = 1'b0;
    assign stable_exit_o = 1'b0;
`endif

    // Every output is forced low while reset is asserted, even before the first edge.
    assign ready_o       = reset_n_i & ready_raw;
    assign update_o      = reset_n_i & update_raw;
    assign v_o           = reset_n_i & v_raw;
    assign busy_o        = reset_n_i & busy_raw;
    assign en_o          = reset_n_i & pacer_en;
    assign frames_done_o = reset_n_i ? frames_done_q : '0;

endmodule

// File: tb/tb_bsg_cgol_seq_ctrl.sv
// Bench for bsg_cgol_seq_ctrl: a cycle model checked every cycle plus directed
// scenarios with hand-computed literals (pacing 3 cycles/frame, max 12 frames).
module tb_bsg_cgol_seq_ctrl;

    localparam int MAX = 12;
    localparam int CPF = 3;
    localparam int GW  = 4;

`ifdef BSG_CGOL_CTRL_STABLE_EXIT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, en, v, stop, stable, yumi;
    logic [GW-1:0] frames;
    logic [1:0]    mode;
    logic          ready, v_o, stable_exit, update, en_o, busy;
    logic [GW-1:0] frames_done;

    always #5 clk = ~clk;

    bsg_cgol_seq_ctrl #(
        .max_game_length_p (MAX),
        .cycles_per_frame_p(CPF)
    ) u_dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .en_i         (en),
        .frames_i     (frames),
        .mode_i       (mode),
        .v_i          (v),
        .ready_o      (ready),
        .stop_i       (stop),
        .stable_i     (stable),
        .v_o          (v_o),
        .yumi_i       (yumi),
        .frames_done_o(frames_done),
        .stable_exit_o(stable_exit),
        .update_o     (update),
        .en_o         (en_o),
        .busy_o       (busy)
    );

    // Model: m_where 0=waiting for command, 1=loading, 2=computing, 3=holding result.
    int m_where = 0, m_target = 0, m_kind = 0, m_done = 0, m_sub = 0, m_stable = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_where = 0; m_done = 0; m_sub = 0; m_stable = 0;
        end else if (m_where == 0) begin
            if (en && v) begin
                m_target = int'(frames);
                m_kind   = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
                m_done   = 0; m_stable = 0; m_where = 1;
            end
        end else if (m_where == 1) begin
            m_sub   = 0;
            m_where = (m_kind == 0 && m_target == 0) ? 3 : 2;
        end else if (m_where == 2) begin
            if (en) begin
                if (m_sub == CPF - 1) begin
                    m_sub  = 0;
                    m_done = m_done + 1;
                    if ((m_kind == 0 && m_done == m_target) || m_kind == 1 ||
                        (m_kind == 2 && m_done == MAX) || stop || (SE && stable)) begin
                        m_where  = 3;
                        m_stable = (SE && stable) ? 1 : 0;
                    end
                end else begin
                    m_sub = m_sub + 1;
                end
            end
        end else if (yumi) begin
            m_where = 0;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        int e_ready;
        e_ready = (rst_n && m_where == 0 && en) ? 1 : 0;
        check("ready_o", int'(ready), e_ready);
        check("update_o", int'(update), (e_ready == 1 && v) ? 1 : 0);
        check("en_o", int'(en_o), (rst_n && m_where == 2 && en && m_sub == 0) ? 1 : 0);
        check("v_o", int'(v_o), (rst_n && m_where == 3) ? 1 : 0);
        check("busy_o", int'(busy), (rst_n && (m_where == 1 || m_where == 2)) ? 1 : 0);
        check("frames_done_o", int'(frames_done), rst_n ? m_done : 0);
        check("stable_exit_o", int'(stable_exit), rst_n ? m_stable : 0);
    endtask

    // k counts cycles after the accepting edge (k=0 is the load cycle).
    task automatic run_cmd(input int md, input int fr, input int stop_k, input int enlo_k,
                           input int stab_k, input int rst_k, input int limit,
                           output int en_cnt, output int lat, output int got_v,
                           output int fd, output int se);
        en_cnt = 0; lat = -1; got_v = 0; fd = -1; se = -1;
        v = 1'b1; mode = 2'(md); frames = GW'(fr);
        @(negedge clk);
        check("ready_at_issue", int'(ready), 1);
        check("update_at_issue", int'(update), 1);
        @(posedge clk); #1;
        v = 1'b0;
        for (int k = 0; k < limit; k++) begin
            stop   = (stop_k >= 0 && k >= stop_k);
            en     = !(enlo_k >= 0 && k >= enlo_k && k < enlo_k + 2);
            stable = (stab_k >= 0 && k >= stab_k);
            rst_n  = (k != rst_k);
            @(negedge clk);
            if (en_o) en_cnt++;
            if (v_o) begin
                lat = k; got_v = 1; fd = int'(frames_done); se = int'(stable_exit);
                break;
            end
            @(posedge clk); #1;
        end
        if (got_v == 1) begin
            @(posedge clk); #1;
        end
        stop = 1'b0; stable = 1'b0; en = 1'b1; rst_n = 1'b1;
        if (got_v == 1) begin
            @(negedge clk);
            check("v_held", int'(v_o), 1);
            @(posedge clk); #1;
            yumi = 1'b1;
            @(posedge clk); #1;
            yumi = 1'b0;
            @(negedge clk);
            check("ready_after_yumi", int'(ready), 1);
            check("v_after_yumi", int'(v_o), 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en, lat, got, fd, se;
        rst_n = 1'b0; en = 1'b1; v = 1'b1; stop = 1'b0; stable = 1'b0; yumi = 1'b0;
        frames = '0; mode = 2'd0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
            begin
                @(negedge clk);
                check("reset_ready", int'(ready), 0);
                check("reset_update", int'(update), 0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                v = 1'b0; rst_n = 1'b1;
                @(posedge clk); #1;

                // v_i with en_i low and yumi_i with no result are both ignored
                en = 1'b0; v = 1'b1; yumi = 1'b1;
                @(negedge clk);
                check("frozen_ready", int'(ready), 0);
                check("frozen_update", int'(update), 0);
                @(posedge clk); #1;
                en = 1'b1; v = 1'b0; yumi = 1'b0;
                @(negedge clk);
                check("frozen_not_busy", int'(busy), 0);
                @(posedge clk); #1;

                run_cmd(0, 5, -1, -1, -1, -1, 60, n_en, lat, got, fd, se);
                check("runn5_got_v", got, 1);
                check("runn5_en_pulses", n_en, 5);
                check("runn5_latency", lat, 16);
                check("runn5_frames", fd, 5);

                run_cmd(0, 0, -1, -1, -1, -1, 60, n_en, lat, got, fd, se);
                check("runn0_en_pulses", n_en, 0);
                check("runn0_latency", lat, 1);
                check("runn0_frames", fd, 0);

                run_cmd(1, 7, -1, -1, -1, -1, 60, n_en, lat, got, fd, se);
                check("step_en_pulses", n_en, 1);
                check("step_latency", lat, 4);
                check("step_frames", fd, 1);

                run_cmd(2, 0, 10, 5, -1, -1, 60, n_en, lat, got, fd, se);
                check("stop_en_pulses", n_en, 3);
                check("stop_latency", lat, 12);
                check("stop_frames", fd, 3);
                check("stop_stable_flag", se, 0);

                run_cmd(0, 10, -1, -1, 5, -1, 60, n_en, lat, got, fd, se);
                check("stable_frames", fd, SE ? 2 : 10);
                check("stable_latency", lat, SE ? 7 : 31);
                check("stable_flag", se, SE ? 1 : 0);

                run_cmd(0, 8, -1, -1, -1, 5, 40, n_en, lat, got, fd, se);
                check("reset_midrun_no_v", got, 0);
                @(negedge clk);
                check("reset_midrun_idle", int'(busy), 0);
                check("reset_midrun_frames", int'(frames_done), 0);
                @(posedge clk); #1;

                run_cmd(2, 0, -1, -1, -1, -1, 60, n_en, lat, got, fd, se);
                check("free_sat_frames", fd, MAX);
                check("free_sat_latency", lat, 1 + MAX * CPF);
                check("free_sat_en_pulses", n_en, MAX);

                run_cmd(3, 2, -1, -1, -1, -1, 60, n_en, lat, got, fd, se);
                check("reserved_frames", fd, 2);
                check("reserved_latency", lat, 7);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
